audio_dac_serializer: RTL

//  Transmit end of the effect chain: takes parallel stereo samples from an effect block
//  (delay, distortion, ...) and serializes them to the codec DAC as I2S (or left-justified).

---
 rtl/audio_dac_serializer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: stereo parallel-to-serial transmitter for a codec DAC.
// Generates BCLK/LRCK from clk, holds one stereo pair, and shifts it out MSB first.
// Build option: define AUDIO_DAC_LJ_EN for left-justified framing (MSB on the LRCK edge);
// without it the output is standard I2S (MSB one BCLK after each LRCK edge).
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  dac_bclk,
  output logic                  dac_lrck,
  output logic                  dac_data,
  output logic                  underrun,
  output logic                  busy
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
`ifdef AUDIO_DAC_LJ_EN
  localparam int MSB_OFS    = 0;
`else
  localparam int MSB_OFS    = 1;
`endif

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LR  = BIT_W'(SLOT_BITS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [CNT_W-1:0]      div_q;
  logic                  bclk_q;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  lrck_q;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
  logic [FRAME_BITS-1:0] sh_q;
  logic                  data_q;
  state_t                state_q, state_d;
  logic                  busy_q, underrun_q;

  logic                  tick, fall, boundary, xfer, accept, underrun_d;
  logic [FRAME_BITS-1:0] load_vec;

  // Place each sample MSB first at offset MSB_OFS within its slot; all other bits are zero.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_WIDTH-1:0] l,
                                                        input logic [DATA_WIDTH-1:0] r);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      f[FRAME_BITS-1-MSB_OFS-i] = l[DATA_WIDTH-1-i];
      f[SLOT_BITS-1-MSB_OFS-i]  = r[DATA_WIDTH-1-i];
    end
    return f;
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign fall     = tick && bclk_q;
  assign boundary = fall && (bit_q == BIT_LAST);
  // A pair moves to the shifter only when the frame will actually be transmitted.
  assign xfer     = boundary && enable && full_q;
  assign in_ready = !full_q || xfer;
  assign accept   = in_valid && in_ready;
  assign bit_d    = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
  assign load_vec = xfer ? build_frame(hold_l_q, hold_r_q) : '0;

  // BCLK divider: free-running, toggles every BCLK_DIV clk cycles in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q  <= div_q + CNT_W'(1);
    end
  end

  // Bit position within the frame and word select, both advanced on BCLK fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_q  <= '0;
      lrck_q <= 1'b0;
    end else if (fall) begin
      bit_q  <= bit_d;
      lrck_q <= (bit_d >= SLOT_LR);
    end
  end

  // Holding register: accept fills it, xfer drains it; both together keep it full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      if (accept) begin
        hold_l_q <= in_left;
        hold_r_q <= in_right;
        full_q   <= 1'b1;
      end else if (xfer) begin
        full_q   <= 1'b0;
      end
    end
  end

  // Next-state decision, taken only at frame boundaries.
  always_comb begin
    state_d    = state_q;
    underrun_d = 1'b0;
    if (boundary) begin
      if (!enable) begin
        state_d = S_IDLE;
      end else if (state_q == S_RUN) begin
        underrun_d = !full_q;
      end else if (full_q) begin
        state_d = S_RUN;
      end
    end
  end

  // FSM state with registered busy flag and one-cycle underrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == S_RUN);
      underrun_q <= underrun_d;
    end
  end

  // Shifter: reload at each boundary (pair or zeros), otherwise shift one bit per fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q   <= '0;
      data_q <= 1'b0;
    end else if (boundary) begin
      data_q <= load_vec[FRAME_BITS-1];
      sh_q   <= load_vec << 1;
    end else if (fall) begin
      data_q <= sh_q[FRAME_BITS-1];
      sh_q   <= sh_q << 1;
    end
  end

  assign dac_bclk = bclk_q;
  assign dac_lrck = lrck_q;
  assign dac_data = data_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule
